// File: rtl/vram_arbiter.sv
// Single-port framebuffer scheduler: display reads, vblank clears and two
// round-robin writers share one RAM port; the scanout pixel is registered here.
module vram_arbiter #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    col,
  input  logic [9:0]    row,
  input  logic          valid,
  input  logic [1:0]    wr_req,
  input  logic [14:0]   wr_addr0,
  input  logic [14:0]   wr_addr1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  output logic [1:0]    wr_gnt,
  input  logic          clear_req,
  input  logic [DW-1:0] clear_color,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [14:0]   mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix,
  output logic          pix_valid
);
  localparam logic [14:0] FB_SIZE   = 15'd19200;
  localparam logic [14:0] LAST_ADDR = 15'd19199;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic          clr_pend;
  logic [14:0]   clr_cnt;
  logic [DW-1:0] clr_color_q;
  logic          rr_ptr;
  logic          disp_d;
  logic          valid_d;

  logic          disp_slot;
  logic          win;
  logic          clr_start;
  logic [14:0]   disp_addr;
  logic [14:0]   sel_addr;
  logic [DW-1:0] sel_data;

  // One stored pixel covers a 4x4 screen block, so only every fourth column reads.
  assign disp_slot = valid && (col[1:0] == 2'b00);
  assign disp_addr = 15'(row[9:2]) * 15'd160 + 15'(col[9:2]);

  assign win        = (wr_req == 2'b11) ? rr_ptr : wr_req[1];
  assign sel_addr   = win ? wr_addr1 : wr_addr0;
  assign sel_data   = win ? wr_data1 : wr_data0;
  assign clr_start  = (state == IDLE) && clr_pend && (row == 10'd480) && (col == 10'd0);
  assign clear_busy = (state == CLEAR);

  always_comb begin
    wr_gnt    = 2'b00;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (disp_slot) begin
        mem_addr = disp_addr;
      end else if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = clr_color_q;
      end else if (wr_req != 2'b00) begin
        wr_gnt    = win ? 2'b10 : 2'b01;
        mem_addr  = sel_addr;
        mem_wdata = sel_data;
        // Off-screen writes are still acknowledged so a writer never stalls.
        mem_we    = (sel_addr < FB_SIZE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clr_pend    <= 1'b0;
      clr_cnt     <= '0;
      clr_color_q <= '0;
      clear_done  <= 1'b0;
      rr_ptr      <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (wr_gnt != 2'b00) begin
        rr_ptr <= ~win;
      end
      if (clear_req) begin
        clr_pend <= 1'b1;
      end else if (clr_start) begin
        clr_pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (clr_start) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            clr_color_q <= clear_color;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 15'd1;
          if (clr_cnt == LAST_ADDR) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data arrives the cycle after a display slot; capture it then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_d    <= 1'b0;
      valid_d   <= 1'b0;
      pix       <= '0;
      pix_valid <= 1'b0;
    end else begin
      disp_d    <= disp_slot;
      valid_d   <= valid;
      pix_valid <= valid_d;
      if (disp_d) begin
        pix <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed-plus-random bench for vram_arbiter: a RAM model answers the port and a
// cycle-indexed reference built from the scheduling rules predicts every output.
module tb_vram_arbiter;
  localparam int DW   = 12;
  localparam int NPIX = 19200;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    col;
  logic [9:0]    row;
  logic          valid;
  logic [1:0]    wr_req;
  logic [14:0]   wr_addr0;
  logic [14:0]   wr_addr1;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic [1:0]    wr_gnt;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic [14:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix;
  logic          pix_valid;
  logic          preload;

  always #5 clk = ~clk;

  vram_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .valid(valid),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix(pix), .pix_valid(pix_valid)
  );

  logic [DW-1:0] ram [NPIX];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= DW'(i);
    end else if (mem_we && mem_addr < 15'(NPIX)) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_addr < 15'(NPIX)) ? ram[mem_addr] : '0;
  end

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } load_t;

  logic [DW-1:0] mram [NPIX];
  load_t         ldq[$];
  bit            vq[$];
  int            cyc;
  int            clr_begin;
  logic [DW-1:0] m_color;
  bit            m_pend;
  int            m_rr;
  logic [DW-1:0] m_pix;
  int            n_checks;
  int            n_fail;
  int            cur_c;
  int            cur_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input logic [1:0] eg, input bit ewe, input logic [14:0] eaddr,
                             input logic [DW-1:0] edata, input bit chk_addr, input bit epv,
                             input bit ebusy, input bit edone);
    chk("wr_gnt", 32'(wr_gnt), 32'(eg));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    if (chk_addr) chk("mem_addr", 32'(mem_addr), 32'(eaddr));
    if (ewe) chk("mem_wdata", 32'(mem_wdata), 32'(edata));
    chk("pix", 32'(pix), 32'(m_pix));
    chk("pix_valid", 32'(pix_valid), 32'(epv));
    chk("clear_busy", 32'(clear_busy), 32'(ebusy));
    chk("clear_done", 32'(clear_done), 32'(edone));
  endtask

  // One clock cycle: drive inputs, predict, compare, then advance the reference.
  task automatic applyStimulus(input logic [9:0] c, input logic [9:0] r,
                               input logic [1:0] req, input bit creq);
    int            k;
    int            win;
    bit            disp;
    bit            clr;
    bit            ewe;
    bit            chk_addr;
    bit            epv;
    logic [1:0]    eg;
    logic [14:0]   eaddr;
    logic [DW-1:0] edata;
    load_t         ld;
    col = c; row = r; wr_req = req; clear_req = creq;
    valid = (c < 10'd640) && (r < 10'd480);
    if (rst) begin
      clr_begin = -1000000; m_pend = 0; m_rr = 0; m_pix = '0;
      ldq.delete(); vq.delete();
    end
    disp = valid && (c % 4 == 0);
    k = cyc - clr_begin;
    clr = (k >= 1) && (k <= NPIX);
    win = (req == 2'b11) ? m_rr : ((req == 2'b10) ? 1 : 0);
    eg = 2'b00; ewe = 0; eaddr = '0; edata = '0; chk_addr = 1;
    if (disp) begin
      eaddr = 15'((r / 4) * 160 + c / 4);
    end else if (clr) begin
      ewe = 1; eaddr = 15'(k - 1); edata = m_color;
    end else if (req != 2'b00) begin
      eg = (win == 1) ? 2'b10 : 2'b01;
      eaddr = (win == 1) ? wr_addr1 : wr_addr0;
      edata = (win == 1) ? wr_data1 : wr_data0;
      ewe = (eaddr < 15'(NPIX));
      chk_addr = ewe;
    end
    if (rst) begin
      eg = 2'b00; ewe = 0; eaddr = '0; chk_addr = 1; disp = 0;
    end
    while (ldq.size() > 0 && ldq[0].due <= cyc) begin
      ld = ldq.pop_front();
      m_pix = ld.val;
    end
    epv = (vq.size() >= 2) ? vq[vq.size() - 2] : 1'b0;
    #3;
    checkOutput(eg, ewe, eaddr, edata, chk_addr, epv, clr && !rst, (k == NPIX + 1) && !rst);
    if (!rst) begin
      if (ewe) mram[eaddr] = edata;
      if (disp) begin
        ld.due = cyc + 2;
        ld.val = mram[eaddr];
        ldq.push_back(ld);
      end
      if (eg != 2'b00) m_rr = 1 - win;
      vq.push_back(valid);
      if (vq.size() > 2) void'(vq.pop_front());
      if (!clr && m_pend && r == 10'd480 && c == 10'd0) begin
        clr_begin = cyc; m_color = clear_color; m_pend = creq;
      end else if (creq) begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic randWriters();
    wr_addr0 = 15'($urandom_range(0, NPIX + 99));
    wr_addr1 = 15'($urandom_range(0, NPIX + 99));
    wr_data0 = DW'($urandom);
    wr_data1 = DW'($urandom);
  endtask

  task automatic advance(input logic [1:0] req, input bit creq);
    applyStimulus(10'(cur_c), 10'(cur_r), req, creq);
    cur_c++;
    if (cur_c == 800) begin
      cur_c = 0;
      cur_r = (cur_r == 524) ? 0 : cur_r + 1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; clr_begin = -1000000;
    m_pend = 0; m_rr = 0; m_pix = '0; m_color = '0;
    for (int i = 0; i < NPIX; i++) mram[i] = DW'(i);
    rst = 1; preload = 1;
    col = '0; row = '0; valid = 0; wr_req = '0; clear_req = 0; clear_color = '0;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    @(posedge clk); #1;
    preload = 0;

    $display("[TB] reset with busy inputs");
    for (int i = 0; i < 3; i++) begin
      randWriters();
      applyStimulus(10'd0, 10'd8, 2'b11, 1'b1);
    end
    rst = 0;

    $display("[TB] display rows 8-9");
    cur_c = 0; cur_r = 8;
    for (int i = 0; i < 16; i++) advance(2'b00, 1'b0);
    for (int i = 16; i < 1600; i++) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] writer 0 in active region");
    cur_c = 4; cur_r = 10;
    randWriters();
    wr_addr0 = 15'd5; wr_data0 = 12'hABC;
    advance(2'b01, 1'b0);
    advance(2'b01, 1'b0);
    chk("ram5_written", 32'(ram[5]), 32'h0ABC);
    while (cur_c != 0) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] round-robin and out-of-range in blanking");
    cur_c = 0; cur_r = 490;
    for (int i = 0; i < 8; i++) begin randWriters(); advance(2'b11, 1'b0); end
    for (int i = 0; i < 4; i++) begin randWriters(); advance(2'b10, 1'b0); end
    randWriters();
    wr_addr1 = 15'd19200;
    advance(2'b10, 1'b0);
    for (int i = 0; i < 200; i++) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] full clear");
    cur_c = 0; cur_r = 100;
    advance(2'b00, 1'b1);
    cur_c = 0; cur_r = 480;
    clear_color = 12'h00F;
    for (int i = 0; i <= NPIX + 2; i++) begin
      if (i > 0) clear_color = DW'($urandom);
      randWriters();
      advance((i <= NPIX) ? 2'($urandom_range(0, 3)) : 2'b00, 1'b0);
    end
    chk("clear_ram_first", 32'(ram[0]), 32'h00F);
    chk("clear_ram_mid", 32'(ram[9600]), 32'h00F);
    chk("clear_ram_last", 32'(ram[NPIX - 1]), 32'h00F);
    cur_c = 0; cur_r = 0;
    for (int i = 0; i < 40; i++) advance(2'b00, 1'b0);

    $display("[TB] reset during clear");
    cur_c = 0; cur_r = 200;
    advance(2'b00, 1'b1);
    cur_c = 0; cur_r = 480;
    for (int i = 0; i <= 5000; i++) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin randWriters(); advance(2'b11, 1'b0); end
    rst = 0;
    for (int i = 0; i < 100; i++) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end
    cur_c = 0; cur_r = 480;
    for (int i = 0; i < 20; i++) begin
      randWriters();
      advance(2'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
